// File: rtl/iris_pkg.sv
// Shared iris definitions: operation encodings and default datapath width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package iris_pkg;

  localparam int IRIS_DATA_WIDTH = 24;

  localparam logic [1:0] MODE_PAIR = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_DIFF = 2'd2;
  localparam logic [1:0] MODE_PASS = 2'd3;

endpackage

// File: rtl/iris_sync_fifo.sv
// Generic synchronous FIFO with registered count, full/empty and a flush input.
// Latency: a pushed entry is readable at the head on the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over both.
module iris_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iris_stream_acc.sv
// Streaming accumulate/combine engine: per-beat PAIR/RUN/DIFF/PASS against held prev/acc state.
// Latency: result enters the output FIFO in the accept cycle, visible one cycle later when empty.
// Backpressure: in_ready drops when the FIFO count reaches depth or clr is high; no path from out_ready.
module iris_stream_acc
  import iris_pkg::*;
#(
  parameter int DATA_WIDTH = IRIS_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int SAT_EN     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [1:0]            mode,
  input  logic                  clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  ovf,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  rdy_q;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH:0]   ext;
  logic                  is_sub;
  logic                  ovf_hit;
  logic [DATA_WIDTH-1:0] res;
  logic                  accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   head;

  assign in_ready  = rdy_q && !fifo_full && !clr;
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign out_last  = fifo_empty ? 1'b0 : head[DATA_WIDTH];

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  // Combine at DATA_WIDTH+1 bits; the top bit is carry (add) or borrow (DIFF).
  always_comb begin
    ext    = '0;
    is_sub = 1'b0;
    case (mode)
      MODE_PAIR: ext = {1'b0, in_data} + {1'b0, prev};
      MODE_RUN:  ext = {1'b0, acc} + {1'b0, in_data};
      MODE_DIFF: begin
        ext    = {1'b0, in_data} - {1'b0, prev};
        is_sub = 1'b1;
      end
      default:   ext = {1'b0, in_data};
    endcase
    ovf_hit = ext[DATA_WIDTH];
    res     = ext[DATA_WIDTH-1:0];
    if (ovf_hit && (SAT_EN != 0)) res = is_sub ? '0 : '1;
  end

  // Held state; clr outranks any beat, in_last restarts the frame after the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev         <= '0;
      acc          <= '0;
      ovf          <= 1'b0;
      sample_count <= '0;
    end else if (clr) begin
      prev         <= '0;
      acc          <= '0;
      ovf          <= 1'b0;
      sample_count <= '0;
    end else if (accept) begin
      prev         <= in_last ? '0 : in_data;
      if (in_last)               acc <= '0;
      else if (mode == MODE_RUN) acc <= res;
      ovf          <= ovf | ovf_hit;
      sample_count <= sample_count + 1'b1;
    end
  end

  iris_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clr),
    .push     (accept),
    .push_dat ({in_last, res}),
    .pop      (out_valid && out_ready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule
